// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch constants, region encoding and the PC region decoder
package riscv_pkg;

    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam logic [1:0]  PCSEL_SEQ   = 2'd0;
    localparam logic [1:0]  PCSEL_JMP   = 2'd1;
    localparam logic [1:0]  PCSEL_NT    = 2'd2;
    localparam logic [3:0]  REGION_BIOS = 4'h4;
    localparam logic [3:0]  REGION_IMEM = 4'h1;

    typedef enum logic [1:0] {
        REG_BIOS,
        REG_IMEM,
        REG_NONE
    } region_e;

    function automatic region_e decode_region(input logic [3:0] top_nibble);
        return (top_nibble == REGION_BIOS) ? REG_BIOS :
               (top_nibble == REGION_IMEM) ? REG_IMEM : REG_NONE;
    endfunction

endpackage

// File: rtl/fetch_counters.sv
// fetch_counters: free-running cycle counter and retired-instruction counter with clear
module fetch_counters
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cnt_clr,
    input  logic        retire,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instret_q, instret_d;

    // clear wins over the increment; both counters wrap naturally
    always_comb begin
        cycle_d   = cnt_clr ? 32'd0 : cycle_q + 32'd1;
        instret_d = cnt_clr ? 32'd0 : instret_q + {31'd0, retire};
    end

    // counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC owner, memory address drive, IF/D instruction select and PC/valid pipe to EX and WB
module fetch_pc_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter int          IMEM_AW  = 14,
    parameter int          BIOS_AW  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         pc_sel,
    input  logic [31:0]        alu_target,
    input  logic               stall,
    input  logic               cnt_clr,
    input  logic [31:0]        imem_dout,
    input  logic [31:0]        bios_dout,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [BIOS_AW-1:0] bios_addr,
    output logic [31:0]        inst_d,
    output logic [31:0]        pc_d,
    output logic [31:0]        pc_x,
    output logic [31:0]        pc4_wb,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        instret_cnt
);

    logic [31:0] pc_f_q, pc_next;
    logic [31:0] pc_x_q, pc4_wb_q;
    logic        v_x_q, v_wb_q;
    logic        redirect, v_d;
    region_e     region;

    // next PC: reset, then EX redirect (beats stall), then hold, then sequential;
    // the decode slot is valid only when not killed and the region is mapped
    always_comb begin
        redirect = pc_sel == PCSEL_JMP;
        pc_next  = rst      ? RESET_PC :
                   redirect ? (alu_target & 32'hFFFF_FFFC) :
                   stall    ? pc_f_q : pc_f_q + 32'd4;
        region   = decode_region(pc_f_q[31:28]);
        v_d      = !(rst || redirect || stall) && (region != REG_NONE);
        inst_d   = !v_d ? NOP_INST : (region == REG_BIOS) ? bios_dout : imem_dout;
    end

    // fetch PC follows pc_next so read data lines up with it next cycle
    always_ff @(posedge clk) begin
        pc_f_q <= pc_next;
    end

    // EX and WB stages never freeze; they advance every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_x_q   <= 32'd0;
            pc4_wb_q <= 32'd0;
            v_x_q    <= 1'b0;
            v_wb_q   <= 1'b0;
        end else begin
            pc_x_q   <= pc_f_q;
            v_x_q    <= v_d;
            pc4_wb_q <= pc_x_q + 32'd4;
            v_wb_q   <= v_x_q;
        end
    end

    assign imem_addr = pc_next[IMEM_AW+1:2];
    assign bios_addr = pc_next[BIOS_AW+1:2];
    assign pc_d      = pc_f_q;
    assign pc_x      = pc_x_q;
    assign pc4_wb    = pc4_wb_q;

    fetch_counters u_cnt (
        .clk         (clk),
        .rst         (rst),
        .cnt_clr     (cnt_clr),
        .retire      (v_wb_q),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: table-driven fetch sequence plus counter wrap and clear sequences
module tb_fetch_pc_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, cnt_clr;
    logic [1:0]  pc_sel;
    logic [31:0] alu_target, imem_dout, bios_dout;
    logic [13:0] imem_addr;
    logic [11:0] bios_addr;
    logic [31:0] inst_d, pc_d, pc_x, pc4_wb, cycle_cnt, instret_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        stall;
        logic [1:0]  pc_sel;
        logic [31:0] tgt;
        logic [31:0] pc_d;
        logic [31:0] inst;
        logic [31:0] pc_x;
        logic [31:0] pc4;
        logic        chk_ir;
        logic [31:0] ir;
    } vec_t;

    vec_t v [18];

    fetch_pc_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pc_sel      (pc_sel),
        .alu_target  (alu_target),
        .stall       (stall),
        .cnt_clr     (cnt_clr),
        .imem_dout   (imem_dout),
        .bios_dout   (bios_dout),
        .imem_addr   (imem_addr),
        .bios_addr   (bios_addr),
        .inst_d      (inst_d),
        .pc_d        (pc_d),
        .pc_x        (pc_x),
        .pc4_wb      (pc4_wb),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] im(input int i);
        return 32'hA000_0000 | i;
    endfunction

    function automatic logic [31:0] bi(input int i);
        return 32'hB000_0000 | i;
    endfunction

    // synchronous-read memories: word contents encode their own address
    always @(posedge clk) begin
        imem_dout <= 32'hA000_0000 | {18'd0, imem_addr};
        bios_dout <= 32'hB000_0000 | {20'd0, bios_addr};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        //          stall pc_sel tgt            pc_d           inst      pc_x           pc4            chk ir
        v[0]  = '{1'b0, 2'd0, 32'h0,          32'h4000_0000, bi(0),  32'h0,          32'h0,          1'b1, 32'd0};
        v[1]  = '{1'b0, 2'd0, 32'h0,          32'h4000_0004, bi(1),  32'h4000_0000, 32'h4,          1'b0, 32'd0};
        v[2]  = '{1'b0, 2'd1, 32'h1000_0010,  32'h4000_0008, NOP,    32'h4000_0004, 32'h4000_0004, 1'b0, 32'd0};
        v[3]  = '{1'b0, 2'd0, 32'h0,          32'h1000_0010, im(4),  32'h4000_0008, 32'h4000_0008, 1'b1, 32'd1};
        v[4]  = '{1'b0, 2'd2, 32'h0,          32'h1000_0014, im(5),  32'h1000_0010, 32'h4000_000C, 1'b0, 32'd0};
        v[5]  = '{1'b0, 2'd3, 32'h0,          32'h1000_0018, im(6),  32'h1000_0014, 32'h1000_0014, 1'b0, 32'd0};
        v[6]  = '{1'b0, 2'd0, 32'h0,          32'h1000_001C, im(7),  32'h1000_0018, 32'h1000_0018, 1'b0, 32'd0};
        v[7]  = '{1'b1, 2'd0, 32'h0,          32'h1000_0020, NOP,    32'h1000_001C, 32'h1000_001C, 1'b0, 32'd0};
        v[8]  = '{1'b1, 2'd0, 32'h0,          32'h1000_0020, NOP,    32'h1000_0020, 32'h1000_0020, 1'b0, 32'd0};
        v[9]  = '{1'b1, 2'd0, 32'h0,          32'h1000_0020, NOP,    32'h1000_0020, 32'h1000_0024, 1'b0, 32'd0};
        v[10] = '{1'b0, 2'd0, 32'h0,          32'h1000_0020, im(8),  32'h1000_0020, 32'h1000_0024, 1'b1, 32'd6};
        v[11] = '{1'b1, 2'd1, 32'h1000_0041,  32'h1000_0024, NOP,    32'h1000_0020, 32'h1000_0024, 1'b0, 32'd0};
        v[12] = '{1'b0, 2'd0, 32'h0,          32'h1000_0040, im(16), 32'h1000_0024, 32'h1000_0024, 1'b0, 32'd0};
        v[13] = '{1'b0, 2'd1, 32'h2000_0000,  32'h1000_0044, NOP,    32'h1000_0040, 32'h1000_0028, 1'b1, 32'd7};
        v[14] = '{1'b0, 2'd0, 32'h0,          32'h2000_0000, NOP,    32'h1000_0044, 32'h1000_0044, 1'b0, 32'd0};
        v[15] = '{1'b0, 2'd1, 32'h4000_0000,  32'h2000_0004, NOP,    32'h2000_0000, 32'h1000_0048, 1'b1, 32'd8};
        v[16] = '{1'b0, 2'd0, 32'h0,          32'h4000_0000, bi(0),  32'h2000_0004, 32'h2000_0004, 1'b0, 32'd0};
        v[17] = '{1'b0, 2'd0, 32'h0,          32'h4000_0004, bi(1),  32'h4000_0000, 32'h2000_0008, 1'b1, 32'd8};

        rst = 1'b1; stall = 1'b0; pc_sel = 2'd0; cnt_clr = 1'b0; alu_target = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset pc_d", pc_d, 32'h4000_0000);
        chk("reset inst_d", inst_d, NOP);
        chk("reset pc_x", pc_x, 32'd0);
        chk("reset pc4_wb", pc4_wb, 32'd0);
        chk("reset cycle", cycle_cnt, 32'd0);
        chk("reset instret", instret_cnt, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            if (i > 0) @(negedge clk);
            stall      = v[i].stall;
            pc_sel     = v[i].pc_sel;
            alu_target = v[i].tgt;
            #1;
            chk($sformatf("row%0d pc_d", i), pc_d, v[i].pc_d);
            chk($sformatf("row%0d inst_d", i), inst_d, v[i].inst);
            chk($sformatf("row%0d pc_x", i), pc_x, v[i].pc_x);
            chk($sformatf("row%0d pc4_wb", i), pc4_wb, v[i].pc4);
            chk($sformatf("row%0d cycle", i), cycle_cnt, i);
            if (v[i].chk_ir) chk($sformatf("row%0d instret", i), instret_cnt, v[i].ir);
        end

        @(negedge clk);
        stall = 1'b0; pc_sel = 2'd0;
        @(negedge clk);
        dut.u_cnt.cycle_q   <= 32'hFFFF_FFFE;
        dut.u_cnt.instret_q <= 32'hFFFF_FFFE;
        repeat (3) @(negedge clk);
        #1;
        chk("wrap cycle", cycle_cnt, 32'd1);
        chk("wrap instret", instret_cnt, 32'd1);
        chk("wrap pc_d", pc_d, 32'h4000_0018);
        chk("wrap inst_d", inst_d, bi(6));
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        chk("clr cycle", cycle_cnt, 32'd0);
        chk("clr instret", instret_cnt, 32'd0);
        @(negedge clk);
        #1;
        chk("post clr cycle", cycle_cnt, 32'd1);
        chk("post clr instret", instret_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
